// File: rtl/pong_pkg.sv
// Shared constants for the Pong game unit: screen geometry, paddle limits,
// quadrature phase encoding and a constant clog2 helper for counter sizing.
package pong_pkg;

  localparam int H_PIXELS     = 640;
  localparam int V_LINES      = 480;
  localparam int PADDLE_WIDTH = 64;

  localparam logic [9:0] PADDLE_MIN_DEF  = 10'd0;
  localparam logic [9:0] PADDLE_MAX_DEF  = 10'd576;
  localparam logic [9:0] PADDLE_INIT_DEF = 10'd288;

  // Encoder phases as {a,b}; clockwise order is 00 -> 10 -> 11 -> 01 -> 00.
  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_10 = 2'b10,
    QS_11 = 2'b11,
    QS_01 = 2'b01
  } quad_state_e;

  // Smallest number of bits b such that 2**b >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/quadrature_filter.sv
// Encoder front end: two-flop synchronisers on both raw lines, a shared
// debounce on the {a,b} pair, and quadrature decode into one-cycle
// inc / dec / err event pulses.
module quadrature_filter
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rota,
  input  logic rotb,
  output logic inc,
  output logic dec,
  output logic err
);

  localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             a_meta_r, a_sync_r, b_meta_r, b_sync_r;
  logic [1:0]       pair_sync_s;
  logic [1:0]       cand_r;
  logic [1:0]       filt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;
  logic             dec_inc_s, dec_dec_s, dec_err_s;
  logic             inc_r, dec_r, err_r;

  assign pair_sync_s = {a_sync_r, b_sync_r};
  assign accept_s    = (cnt_r == CNT_LAST) && (cand_r != filt_r);

  // Two-flop synchronisers for the asynchronous encoder lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta_r <= 1'b0;
      a_sync_r <= 1'b0;
      b_meta_r <= 1'b0;
      b_sync_r <= 1'b0;
    end else begin
      a_meta_r <= rota;
      a_sync_r <= a_meta_r;
      b_meta_r <= rotb;
      b_sync_r <= b_meta_r;
    end
  end

  // Candidate tracking: any change restarts the stability count, which saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_r <= 2'b00;
      cnt_r  <= '0;
    end else if (pair_sync_s != cand_r) begin
      cand_r <= pair_sync_s;
      cnt_r  <= '0;
    end else if (cnt_r != CNT_LAST) begin
      cnt_r  <= cnt_r + CNT_ONE;
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  // Classify the filtered-to-candidate transition as CW, CCW or illegal jump.
  always_comb begin
    dec_inc_s = 1'b0;
    dec_dec_s = 1'b0;
    dec_err_s = 1'b0;
    case ({filt_r, cand_r})
      {QS_00, QS_10}, {QS_10, QS_11}, {QS_11, QS_01}, {QS_01, QS_00}: dec_inc_s = 1'b1;
      {QS_10, QS_00}, {QS_11, QS_10}, {QS_01, QS_11}, {QS_00, QS_01}: dec_dec_s = 1'b1;
      {QS_00, QS_11}, {QS_11, QS_00}, {QS_10, QS_01}, {QS_01, QS_10}: dec_err_s = 1'b1;
      default: begin
        dec_inc_s = 1'b0;
        dec_dec_s = 1'b0;
        dec_err_s = 1'b0;
      end
    endcase
  end

  // Accept a stable pair: update the filtered state and emit one event pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r <= 2'b00;
      inc_r  <= 1'b0;
      dec_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      filt_r <= accept_s ? cand_r : filt_r;
      inc_r  <= accept_s & dec_inc_s;
      dec_r  <= accept_s & dec_dec_s;
      err_r  <= accept_s & dec_err_s;
    end
  end

  assign inc = inc_r;
  assign dec = dec_r;
  assign err = err_r;

endmodule

// File: rtl/rotary_paddle_controller.sv
// Rotary-encoder paddle input for Pong: accumulates decoded quadrature
// transitions into detents, moves a saturating paddle position and keeps a
// frame-latched copy so the renderer never sees mid-frame movement.
module rotary_paddle_controller
  import pong_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES        = 50000,
  parameter int         TRANSITIONS_PER_DETENT = 4,
  parameter logic [9:0] STEP                   = 10'd8,
  parameter logic [9:0] PADDLE_MIN             = PADDLE_MIN_DEF,
  parameter logic [9:0] PADDLE_MAX             = PADDLE_MAX_DEF,
  parameter logic [9:0] PADDLE_INIT            = PADDLE_INIT_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       rota,
  input  logic       rotb,
  input  logic       FrameStart,
  output logic [9:0] paddle_pos,
  output logic [9:0] paddle_frame,
  output logic       step_cw,
  output logic       step_ccw,
  output logic       quad_error
);

  localparam int SUB_W = clog2(TRANSITIONS_PER_DETENT + 1) + 1;
  localparam logic signed [SUB_W-1:0] SUB_ONE = SUB_W'(1);
  localparam logic signed [SUB_W-1:0] SUB_TOP = SUB_W'(TRANSITIONS_PER_DETENT - 1);
  localparam logic signed [SUB_W-1:0] SUB_BOT = -SUB_TOP;

  logic                    ev_inc_s, ev_dec_s, ev_err_s;
  logic signed [SUB_W-1:0] sub_r, sub_next_s;
  logic                    step_cw_r, step_ccw_r, cw_next_s, ccw_next_s;
  logic [9:0]              paddle_pos_r, pos_next_s, paddle_frame_r;
  logic [10:0]             sum_s;
  logic signed [11:0]      diff_s;

  quadrature_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter (
    .clk  (Clock),
    .rst_n(Reset),
    .rota (rota),
    .rotb (rotb),
    .inc  (ev_inc_s),
    .dec  (ev_dec_s),
    .err  (ev_err_s)
  );

  // Sub-count: a full detent in either direction emits a step and clears it.
  always_comb begin
    sub_next_s = sub_r;
    cw_next_s  = 1'b0;
    ccw_next_s = 1'b0;
    if (ev_inc_s) begin
      if (sub_r == SUB_TOP) begin
        sub_next_s = '0;
        cw_next_s  = 1'b1;
      end else begin
        sub_next_s = sub_r + SUB_ONE;
      end
    end else if (ev_dec_s) begin
      if (sub_r == SUB_BOT) begin
        sub_next_s = '0;
        ccw_next_s = 1'b1;
      end else begin
        sub_next_s = sub_r - SUB_ONE;
      end
    end else begin
      sub_next_s = sub_r;
    end
  end

  // Next paddle position, clamped with widened arithmetic so nothing wraps.
  always_comb begin
    sum_s      = {1'b0, paddle_pos_r} + {1'b0, STEP};
    diff_s     = $signed({2'b00, paddle_pos_r}) - $signed({2'b00, STEP});
    pos_next_s = paddle_pos_r;
    if (step_cw_r) begin
      pos_next_s = (sum_s > {1'b0, PADDLE_MAX}) ? PADDLE_MAX : sum_s[9:0];
    end else if (step_ccw_r) begin
      pos_next_s = (diff_s < $signed({2'b00, PADDLE_MIN})) ? PADDLE_MIN : diff_s[9:0];
    end else begin
      pos_next_s = paddle_pos_r;
    end
  end

  // State registers: sub-count, step pulses, position and frame latch.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sub_r          <= '0;
      step_cw_r      <= 1'b0;
      step_ccw_r     <= 1'b0;
      paddle_pos_r   <= PADDLE_INIT;
      paddle_frame_r <= PADDLE_INIT;
    end else begin
      sub_r          <= sub_next_s;
      step_cw_r      <= cw_next_s;
      step_ccw_r     <= ccw_next_s;
      paddle_pos_r   <= pos_next_s;
      paddle_frame_r <= FrameStart ? paddle_pos_r : paddle_frame_r;
    end
  end

  assign paddle_pos   = paddle_pos_r;
  assign paddle_frame = paddle_frame_r;
  assign step_cw      = step_cw_r;
  assign step_ccw     = step_ccw_r;
  assign quad_error   = ev_err_s;

endmodule

// File: tb/tb_rotary_paddle_controller.sv
// Directed bench for rotary_paddle_controller with a shortened debounce
// window so whole-detent scenarios run in a few thousand clocks.
module tb_rotary_paddle_controller;

  localparam int D    = 16;
  localparam int HOLD = 30;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       rota, rotb, FrameStart;
  logic [9:0] paddle_pos, paddle_frame;
  logic       step_cw, step_ccw, quad_error;

  int n_cmp = 0;
  int n_bad = 0;
  int cw_total = 0, ccw_total = 0, err_total = 0;
  int max_pos_seen = 0;

  rotary_paddle_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .Clock(Clock), .Reset(Reset), .rota(rota), .rotb(rotb),
    .FrameStart(FrameStart), .paddle_pos(paddle_pos), .paddle_frame(paddle_frame),
    .step_cw(step_cw), .step_ccw(step_ccw), .quad_error(quad_error)
  );

  always #5 Clock = ~Clock;

  // Pulse counters and highest position observed, sampled away from the active edge.
  always @(negedge Clock) begin
    if (step_cw === 1'b1) cw_total = cw_total + 1;
    if (step_ccw === 1'b1) ccw_total = ccw_total + 1;
    if (quad_error === 1'b1) err_total = err_total + 1;
    if (int'(paddle_pos) > max_pos_seen) max_pos_seen = int'(paddle_pos);
  end

  task automatic set_lines(input logic a, input logic b);
    @(negedge Clock);
    rota = a;
    rotb = b;
    repeat (HOLD) @(negedge Clock);
  endtask

  task automatic cw_detent();
    set_lines(1'b1, 1'b0); set_lines(1'b1, 1'b1); set_lines(1'b0, 1'b1); set_lines(1'b0, 1'b0);
  endtask

  task automatic ccw_detent();
    set_lines(1'b0, 1'b1); set_lines(1'b1, 1'b1); set_lines(1'b1, 1'b0); set_lines(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    Reset = 1'b0; rota = 1'b0; rotb = 1'b0; FrameStart = 1'b0;
    repeat (5) @(negedge Clock);
    n_cmp++; if (paddle_pos !== 10'd288) begin n_bad++; $display("FAIL reset_pos: got %0d expected 288", paddle_pos); end
    n_cmp++; if (paddle_frame !== 10'd288) begin n_bad++; $display("FAIL reset_frame: got %0d expected 288", paddle_frame); end
    n_cmp++; if ({step_cw, step_ccw, quad_error} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b expected 000", {step_cw, step_ccw, quad_error}); end
    Reset = 1'b1;
    repeat (100) @(negedge Clock);
    n_cmp++; if (paddle_pos !== 10'd288) begin n_bad++; $display("FAIL idle_pos: got %0d expected 288", paddle_pos); end
    n_cmp++; if (paddle_frame !== 10'd288) begin n_bad++; $display("FAIL idle_frame: got %0d expected 288", paddle_frame); end
    n_cmp++; if (cw_total + ccw_total + err_total !== 0) begin n_bad++; $display("FAIL idle_pulses: got %0d expected 0", cw_total + ccw_total + err_total); end
  endtask

  task automatic test_cw_ccw_detent();
    int  cw0, ccw0;
    logic found;
    cw0 = cw_total; ccw0 = ccw_total;
    set_lines(1'b1, 1'b0); set_lines(1'b1, 1'b1); set_lines(1'b0, 1'b1);
    n_cmp++; if (cw_total - cw0 !== 0) begin n_bad++; $display("FAIL cw_early: got %0d steps expected 0", cw_total - cw0); end
    @(negedge Clock);
    rota = 1'b0; rotb = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge Clock);
      if (step_cw === 1'b1) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL cw_pulse_timeout: got %b expected 1", found); end
    n_cmp++; if (paddle_pos !== 10'd288) begin n_bad++; $display("FAIL cw_pos_at_pulse: got %0d expected 288", paddle_pos); end
    @(negedge Clock);
    n_cmp++; if (paddle_pos !== 10'd296) begin n_bad++; $display("FAIL cw_pos_after: got %0d expected 296", paddle_pos); end
    repeat (HOLD) @(negedge Clock);
    n_cmp++; if (cw_total - cw0 !== 1) begin n_bad++; $display("FAIL cw_count: got %0d expected 1", cw_total - cw0); end
    ccw_detent();
    n_cmp++; if (paddle_pos !== 10'd288) begin n_bad++; $display("FAIL ccw_pos: got %0d expected 288", paddle_pos); end
    n_cmp++; if (ccw_total - ccw0 !== 1) begin n_bad++; $display("FAIL ccw_count: got %0d expected 1", ccw_total - ccw0); end
  endtask

  task automatic test_glitch();
    int cw0, ccw0;
    cw0 = cw_total; ccw0 = ccw_total;
    // Three CW transitions, then glitches that would complete the detent if accepted.
    set_lines(1'b1, 1'b0); set_lines(1'b1, 1'b1); set_lines(1'b0, 1'b1);
    @(negedge Clock); rotb = 1'b0; repeat (D / 2) @(negedge Clock); rotb = 1'b1;
    repeat (HOLD) @(negedge Clock);
    @(negedge Clock); rotb = 1'b0; repeat (2) @(negedge Clock); rotb = 1'b1;
    repeat (HOLD) @(negedge Clock);
    n_cmp++; if (cw_total - cw0 !== 0) begin n_bad++; $display("FAIL glitch_cw: got %0d steps expected 0", cw_total - cw0); end
    set_lines(1'b0, 1'b0);
    n_cmp++; if (paddle_pos !== 10'd296) begin n_bad++; $display("FAIL glitch_cw_pos: got %0d expected 296", paddle_pos); end
    // Three CCW transitions, then rota glitches toward the final phase.
    set_lines(1'b0, 1'b1); set_lines(1'b1, 1'b1); set_lines(1'b1, 1'b0);
    @(negedge Clock); rota = 1'b0; repeat (D / 2) @(negedge Clock); rota = 1'b1;
    repeat (HOLD) @(negedge Clock);
    @(negedge Clock); rota = 1'b0; repeat (2) @(negedge Clock); rota = 1'b1;
    repeat (HOLD) @(negedge Clock);
    n_cmp++; if (ccw_total - ccw0 !== 0) begin n_bad++; $display("FAIL glitch_ccw: got %0d steps expected 0", ccw_total - ccw0); end
    set_lines(1'b0, 1'b0);
    n_cmp++; if (paddle_pos !== 10'd288) begin n_bad++; $display("FAIL glitch_ccw_pos: got %0d expected 288", paddle_pos); end
  endtask

  task automatic test_saturation();
    int cw0, ccw0;
    cw0 = cw_total; ccw0 = ccw_total;
    for (int i = 0; i < 80; i++) cw_detent();
    n_cmp++; if (cw_total - cw0 !== 80) begin n_bad++; $display("FAIL sat_cw_count: got %0d expected 80", cw_total - cw0); end
    n_cmp++; if (paddle_pos !== 10'd576) begin n_bad++; $display("FAIL sat_max_pos: got %0d expected 576", paddle_pos); end
    n_cmp++; if (max_pos_seen > 576) begin n_bad++; $display("FAIL sat_max_seen: got %0d expected <= 576", max_pos_seen); end
    for (int i = 0; i < 80; i++) ccw_detent();
    n_cmp++; if (ccw_total - ccw0 !== 80) begin n_bad++; $display("FAIL sat_ccw_count: got %0d expected 80", ccw_total - ccw0); end
    n_cmp++; if (paddle_pos !== 10'd0) begin n_bad++; $display("FAIL sat_min_pos: got %0d expected 0", paddle_pos); end
    n_cmp++; if (max_pos_seen > 576) begin n_bad++; $display("FAIL sat_no_wrap: got %0d expected <= 576", max_pos_seen); end
  endtask

  task automatic test_illegal_and_frame();
    int   cw0, ccw0, err0;
    logic found;
    cw0 = cw_total; ccw0 = ccw_total; err0 = err_total;
    set_lines(1'b1, 1'b1);
    n_cmp++; if (err_total - err0 !== 1) begin n_bad++; $display("FAIL illegal_err: got %0d expected 1", err_total - err0); end
    set_lines(1'b0, 1'b0);
    n_cmp++; if (err_total - err0 !== 2) begin n_bad++; $display("FAIL illegal_err_back: got %0d expected 2", err_total - err0); end
    n_cmp++; if (cw_total - cw0 + ccw_total - ccw0 !== 0) begin n_bad++; $display("FAIL illegal_steps: got %0d expected 0", cw_total - cw0 + ccw_total - ccw0); end
    n_cmp++; if (paddle_pos !== 10'd0) begin n_bad++; $display("FAIL illegal_pos: got %0d expected 0", paddle_pos); end
    set_lines(1'b1, 1'b0); set_lines(1'b1, 1'b1); set_lines(1'b0, 1'b1);
    @(negedge Clock);
    rota = 1'b0; rotb = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge Clock);
      if (step_cw === 1'b1) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL frame_pulse_timeout: got %b expected 1", found); end
    FrameStart = 1'b1;
    @(negedge Clock);
    FrameStart = 1'b0;
    n_cmp++; if (paddle_pos !== 10'd8) begin n_bad++; $display("FAIL frame_live_pos: got %0d expected 8", paddle_pos); end
    n_cmp++; if (paddle_frame !== 10'd0) begin n_bad++; $display("FAIL frame_old: got %0d expected 0", paddle_frame); end
    @(negedge Clock); FrameStart = 1'b1;
    @(negedge Clock); FrameStart = 1'b0;
    n_cmp++; if (paddle_frame !== 10'd8) begin n_bad++; $display("FAIL frame_new: got %0d expected 8", paddle_frame); end
    repeat (HOLD) @(negedge Clock);
    n_cmp++; if (cw_total - cw0 !== 1) begin n_bad++; $display("FAIL frame_cw_count: got %0d expected 1", cw_total - cw0); end
  endtask

  task automatic test_reset_mid_detent();
    int cw0;
    set_lines(1'b1, 1'b0); set_lines(1'b1, 1'b1);
    @(negedge Clock);
    Reset = 1'b0; rota = 1'b0; rotb = 1'b0;
    #1;
    n_cmp++; if (paddle_pos !== 10'd288) begin n_bad++; $display("FAIL midreset_async_pos: got %0d expected 288", paddle_pos); end
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    repeat (HOLD) @(negedge Clock);
    cw0 = cw_total;
    set_lines(1'b1, 1'b0); set_lines(1'b1, 1'b1); set_lines(1'b0, 1'b1);
    n_cmp++; if (cw_total - cw0 !== 0) begin n_bad++; $display("FAIL midreset_early: got %0d steps expected 0", cw_total - cw0); end
    set_lines(1'b0, 1'b0);
    n_cmp++; if (cw_total - cw0 !== 1) begin n_bad++; $display("FAIL midreset_count: got %0d expected 1", cw_total - cw0); end
    n_cmp++; if (paddle_pos !== 10'd296) begin n_bad++; $display("FAIL midreset_pos: got %0d expected 296", paddle_pos); end
  endtask

  initial begin
    test_reset();
    test_cw_ccw_detent();
    test_glitch();
    test_saturation();
    test_illegal_and_frame();
    test_reset_mid_detent();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rotary_paddle_controller.md
Name: rotary_paddle_controller

Overview:
- Upstream input stage for the Pong game unit.
- Takes raw rotary-encoder lines (rota, rotb) from the board, synchronises and debounces them, and decodes quadrature direction.
- Maintains a saturating 10-bit paddle position in pixel coordinates.
- Presents a frame-latched copy of the position so the game/render logic never sees the paddle move mid-frame.

Parameters:
DEBOUNCE_CYCLES, 50000, clocks the {a,b} pair must be stable before acceptance (0.5 ms at 100 MHz)
TRANSITIONS_PER_DETENT, 4, valid quadrature transitions accumulated per paddle step
STEP, 10'd8, pixels moved per detent
PADDLE_MIN, 10'd0, lowest legal position
PADDLE_MAX, 10'd576, highest legal position (640 minus 64-pixel paddle)
PADDLE_INIT, 10'd288, position after reset

Ports:
Clock  input  1  system clock, 100 MHz
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rota  input  1  raw encoder channel A, asynchronous
rotb  input  1  raw encoder channel B, asynchronous
FrameStart  input  1  one-cycle pulse at start of vertical blanking
paddle_pos  output  10  live paddle position
paddle_frame  output  10  position latched at last FrameStart
step_cw  output  1  one-cycle pulse: clockwise detent accepted
step_ccw  output  1  one-cycle pulse: counter-clockwise detent accepted
quad_error  output  1  one-cycle pulse: illegal two-bit jump seen

Behaviour:
- Reset (Reset=0, async): sync flops 0; filtered pair 2'b00; debounce counter 0; sub-count 0; paddle_pos and paddle_frame = PADDLE_INIT; all pulses 0.
- Synchronise: rota and rotb each pass through a 2-flop synchroniser.
- Debounce:
  - The synchronised pair is compared with a candidate register.
  - On any difference, load the candidate and clear the counter.
  - Otherwise increment the counter, saturating.
  - When the counter reaches DEBOUNCE_CYCLES-1 and candidate != filtered pair, update the filtered pair and produce one decode event.
  - Latency from a stable raw edge to the decode event is 2 + DEBOUNCE_CYCLES clocks.
- Decode ({a,b} old -> new):
  - CW sequence 00->10->11->01->00: sub-count +1.
  - CCW sequence is the reverse: sub-count -1.
  - Both bits change: no count; quad_error pulses 1 cycle; filtered pair still updated.
- Sub-count: signed, width sufficient for ±TRANSITIONS_PER_DETENT.
  - Reaching +TRANSITIONS_PER_DETENT: step_cw pulses and the sub-count clears.
  - Reaching -TRANSITIONS_PER_DETENT: step_ccw pulses and the sub-count clears.
  - A direction reversal simply decrements or increments; there is no reset on reversal.
- Position: updated on the clock after the step pulse (pulse at cycle N, paddle_pos changes at N+1).
  - step_cw: paddle_pos = min(paddle_pos + STEP, PADDLE_MAX), computed in 11 bits to avoid wrap.
  - step_ccw: paddle_pos = max(paddle_pos - STEP, PADDLE_MIN), computed signed to avoid underflow wrap.
  - At a limit, further steps still pulse step_cw/step_ccw, but the position is unchanged.
- Frame latch: on FrameStart, paddle_frame <= current registered paddle_pos.
  - If FrameStart coincides with a position update, the pre-update value is captured; the new value appears at the next FrameStart.
- A reset assertion mid-operation (mid-debounce, mid-detent) discards all partial state immediately. After release, the first accepted pair may be an illegal jump from 00 (e.g. encoder resting at 11); this gives one quad_error and no movement.

Decomposition:
- Shared package pong_pkg: screen constants (H_PIXELS=640, V_LINES=480), PADDLE_WIDTH=64, default PADDLE_MIN/MAX/INIT, the 2-bit quadrature state encoding constants, and a clog2 function for the counter width.
- One sub-module, quadrature_filter: synchroniser, debounce, and decode. Outputs are the inc/dec/err event pulses.
- The top level holds the sub-count, position and frame latch.

Test Plan:
- Reset held, then released with rota=rotb=0 idle for 10 µs: paddle_pos = paddle_frame = 288, no pulses.
- One full CW cycle (00->10->11->01->00), each phase held 1 ms: exactly one step_cw, and paddle_pos goes 288 -> 296 one clock after the pulse. The same cycle CCW returns it to 288.
- Glitch: rota pulses high for 1000 clocks (< DEBOUNCE_CYCLES) between valid phases: no decode event, no position change. A 2-clock runt is also ignored.
- Saturation: 80 CW detents from 288: paddle_pos reaches 576 and stays; step_cw still pulses 80 times. Mirror test with CCW detents ends at 0 with no wrap to 1016.
- Illegal jump 00->11 (both lines switched together, held 1 ms): one quad_error, sub-count and position unchanged. Then FrameStart coinciding with a position-update cycle: paddle_frame holds the old value; the next FrameStart shows the new one.
- Reset asserted after 2 of 4 transitions of a CW detent, then released and a full CW cycle applied: exactly one step_cw, and position 296 (not early).
